// File: rtl/fifo_wr_arbiter.sv
// Round-robin scheduler that shares the FIFO memory write port among NREQ requesters.
// It also owns the write-side binary pointer and the Gray copy consumed by the read domain.
module fifo_wr_arbiter #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 4,
    localparam int OW      = $clog2(NREQ)
) (
    input  logic                     wclk,
    input  logic                     wrst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          last,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    input  logic                     wfull,
    output logic [NREQ-1:0]          ack,
    output logic                     wen,
    output logic [ADDRSIZE-1:0]      waddr,
    output logic [DATASIZE-1:0]      wdata,
    output logic [ADDRSIZE:0]        wbin,
    output logic [ADDRSIZE:0]        wptr,
    output logic [OW-1:0]            owner,
    output logic                     busy
);

    localparam int CW = $clog2(MAXBURST + 1);
    localparam int PW = ADDRSIZE + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_n;
    logic [OW-1:0]   owner_n;
    logic [OW-1:0]   rr_ptr, rr_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [PW-1:0]   wbin_n;
    logic            found;
    logic [OW-1:0]   pick;
    int              idx;

    always_comb begin
        state_n = state;
        owner_n = owner;
        rr_n    = rr_ptr;
        cnt_n   = cnt;
        wbin_n  = wbin;
        wen     = 1'b0;
        ack     = '0;
        found   = 1'b0;
        pick    = '0;
        idx     = 0;
        wdata   = req_data[int'(owner)*DATASIZE +: DATASIZE];

        case (state)
            IDLE: begin
                // First requesting lane at or after rr_ptr, scanning cyclically.
                for (int k = 0; k < NREQ; k++) begin
                    idx = (int'(rr_ptr) + k) % NREQ;
                    if (!found && req[idx]) begin
                        found = 1'b1;
                        pick  = OW'(idx);
                    end
                end
                if (found) begin
                    owner_n = pick;
                    cnt_n   = '0;
                    state_n = BURST;
                end
            end
            BURST: begin
                // Gating with wrst keeps a reset cycle from touching memory.
                wen        = req[owner] & ~wfull & ~wrst;
                ack[owner] = wen;
                if (wen) begin
                    wbin_n = wbin + PW'(1);
                    cnt_n  = cnt + CW'(1);
                    if (last[owner] || cnt_n == CW'(MAXBURST)) begin
                        state_n = IDLE;
                        rr_n    = OW'((int'(owner) + 1) % NREQ);
                    end
                end else if (!req[owner]) begin
                    state_n = IDLE;
                    rr_n    = OW'((int'(owner) + 1) % NREQ);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
            wbin   <= '0;
            wptr   <= '0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            rr_ptr <= rr_n;
            cnt    <= cnt_n;
            wbin   <= wbin_n;
            wptr   <= wbin_n ^ (wbin_n >> 1);
        end
    end

    assign waddr = wbin[ADDRSIZE-1:0];
    assign busy  = (state == BURST);

endmodule
